// File: rtl/corevx_tlb_pkg.sv
// Shared definitions for the set-associative Sv32 TLB: command codes, PTE flag
// positions and the flush-sweep FSM states.
package corevx_tlb_pkg;

  localparam logic [1:0] TLB_CMD_NONE    = 2'd0;
  localparam logic [1:0] TLB_CMD_RESOLVE = 2'd1;
  localparam logic [1:0] TLB_CMD_WRITE   = 2'd2;
  localparam logic [1:0] TLB_CMD_FLUSH   = 2'd3;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  typedef logic [0:0] tlb_state_t;
  localparam tlb_state_t ST_IDLE  = 1'b0;
  localparam tlb_state_t ST_SWEEP = 1'b1;

  // A direct-mapped TLB still needs a 1-bit way index.
  function automatic int way_idx_w(input int ways_w);
    return (ways_w > 0) ? ways_w : 1;
  endfunction

endpackage

// File: rtl/corevx_tlb_assoc_if.sv
// Command/result bundle between the LSU, the page-table walker and the TLB.
interface corevx_tlb_assoc_if
  import corevx_tlb_pkg::*;
#(
  parameter int WAYS_W = 2,
  parameter int VPN_W  = 20,
  parameter int PPN_W  = 22,
  parameter int ASID_W = 9
);
  localparam int HWW = way_idx_w(WAYS_W);

  // Handshake: command != NONE is the valid; !busy is the ready. A command is
  // taken exactly on a cycle where both hold; a command presented while busy is
  // dropped, not stalled, so the requester must not assume it was taken.
  logic [1:0]        command;
  logic [VPN_W-1:0]  vpn;
  logic [ASID_W-1:0] asid;
  logic [VPN_W-1:0]  vpn_w;
  logic [ASID_W-1:0] asid_w;
  logic [7:0]        accesstag_w;
  logic [PPN_W-1:0]  phys_w;

  logic              resolve_done;
  logic              hit;
  logic              multi_hit;
  logic [HWW-1:0]    hit_way;
  logic [7:0]        accesstag_r;
  logic [PPN_W-1:0]  phys_r;
  logic              busy;
  tlb_state_t        dbg_state;

  modport master (
    output command, vpn, asid, vpn_w, asid_w, accesstag_w, phys_w,
    input  resolve_done, hit, multi_hit, hit_way, accesstag_r, phys_r, busy, dbg_state
  );

  modport slave (
    input  command, vpn, asid, vpn_w, asid_w, accesstag_w, phys_w,
    output resolve_done, hit, multi_hit, hit_way, accesstag_r, phys_r, busy, dbg_state
  );

endinterface

// File: rtl/corevx_tlb_assoc_way.sv
// One TLB way: tag/ASID/PPN/flag storage plus the compare against the lookup
// key captured alongside the RAM read.
module corevx_tlb_assoc_way
  import corevx_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 4,
  parameter int VPN_W     = 20,
  parameter int PPN_W     = 22,
  parameter int ASID_W    = 9,
  localparam int TAG_W    = VPN_W - ENTRIES_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ENTRIES_W-1:0] waddr,
  input  logic [TAG_W-1:0]     w_vtag,
  input  logic [ASID_W-1:0]    w_asid,
  input  logic [PPN_W-1:0]     w_ppn,
  input  logic [7:0]           w_flags,
  input  logic                 re,
  input  logic [ENTRIES_W-1:0] raddr,
  input  logic [TAG_W-1:0]     r_vtag,
  input  logic [ASID_W-1:0]    r_asid,
  input  logic                 r_valid,
  output logic                 match,
  output logic [PPN_W-1:0]     ppn,
  output logic [7:0]           flags
);
  localparam int DW = TAG_W + ASID_W + PPN_W + 8;

  logic [DW-1:0]     rd_data;
  logic [TAG_W-1:0]  e_vtag;
  logic [ASID_W-1:0] e_asid;
  logic [TAG_W-1:0]  cmp_vtag_q, cmp_vtag_d;
  logic [ASID_W-1:0] cmp_asid_q, cmp_asid_d;
  logic              cmp_valid_q, cmp_valid_d;

  mem_1w1r #(.W(DW), .AW(ENTRIES_W)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata ({w_vtag, w_asid, w_ppn, w_flags}),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

  // The key and the valid bit are captured with the read so a later write or
  // flush cannot disturb a result that is already in flight.
  always_comb begin
    cmp_vtag_d  = cmp_vtag_q;
    cmp_asid_d  = cmp_asid_q;
    cmp_valid_d = cmp_valid_q;
    if (re) begin
      cmp_vtag_d  = r_vtag;
      cmp_asid_d  = r_asid;
      cmp_valid_d = r_valid;
    end
  end

  always_ff @(posedge clk) begin
    cmp_vtag_q  <= cmp_vtag_d;
    cmp_asid_q  <= cmp_asid_d;
    cmp_valid_q <= cmp_valid_d;
  end

  assign {e_vtag, e_asid, ppn, flags} = rd_data;
  assign match = cmp_valid_q && (e_vtag == cmp_vtag_q) &&
                 (flags[PTE_G] || (e_asid == cmp_asid_q));

endmodule

// File: rtl/mem_1w1r.sv
// One-write one-read RAM with a registered read port that holds its last value.
module mem_1w1r #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/corevx_tlb_assoc.sv
// Set-associative Sv32 TLB: valid flops, per-set round-robin victim pointers,
// hit priority/multi-hit detection and the invalidate-all sweep.
module corevx_tlb_assoc
  import corevx_tlb_pkg::*;
#(
  parameter int ENTRIES_W = 4,
  parameter int WAYS_W    = 2,
  parameter int VPN_W     = 20,
  parameter int PPN_W     = 22,
  parameter int ASID_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  corevx_tlb_assoc_if.slave bus
);
  localparam int SETS  = 2**ENTRIES_W;
  localparam int WAYS  = 2**WAYS_W;
  localparam int HWW   = way_idx_w(WAYS_W);

  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      valid_d [SETS];
  logic [HWW-1:0]       rr_q    [SETS];
  logic [HWW-1:0]       rr_d    [SETS];
  tlb_state_t           state_q, state_d;
  logic [ENTRIES_W-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 res_vld_q, res_vld_d;

  logic                 idle, do_resolve, do_write, do_flush;
  logic [ENTRIES_W-1:0] r_set, w_set;
  logic [HWW-1:0]       victim;
  logic [WAYS-1:0]      way_we, match;
  logic [PPN_W-1:0]     way_ppn   [WAYS];
  logic [7:0]           way_flags [WAYS];
  logic [HWW-1:0]       sel_way;
  logic [PPN_W-1:0]     sel_ppn;
  logic [7:0]           sel_flags;

  assign idle       = (state_q == ST_IDLE);
  assign do_resolve = idle && (bus.command == TLB_CMD_RESOLVE);
  assign do_write   = idle && (bus.command == TLB_CMD_WRITE);
  assign do_flush   = idle && (bus.command == TLB_CMD_FLUSH);
  assign r_set      = bus.vpn[ENTRIES_W-1:0];
  assign w_set      = bus.vpn_w[ENTRIES_W-1:0];

  // Lowest invalid way wins; round-robin only when the set is full.
  always_comb begin
    victim = rr_q[w_set];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_q[w_set][i]) victim = HWW'(i);
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign way_we[g] = do_write && (victim == HWW'(g));

    corevx_tlb_assoc_way #(
      .ENTRIES_W (ENTRIES_W),
      .VPN_W     (VPN_W),
      .PPN_W     (PPN_W),
      .ASID_W    (ASID_W)
    ) u_way (
      .clk     (clk),
      .we      (way_we[g]),
      .waddr   (w_set),
      .w_vtag  (bus.vpn_w[VPN_W-1:ENTRIES_W]),
      .w_asid  (bus.asid_w),
      .w_ppn   (bus.phys_w),
      .w_flags (bus.accesstag_w),
      .re      (do_resolve),
      .raddr   (r_set),
      .r_vtag  (bus.vpn[VPN_W-1:ENTRIES_W]),
      .r_asid  (bus.asid),
      .r_valid (valid_q[r_set][g]),
      .match   (match[g]),
      .ppn     (way_ppn[g]),
      .flags   (way_flags[g])
    );
  end

  always_comb begin
    valid_d   = valid_q;
    rr_d      = rr_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = do_resolve;
    res_vld_d = res_vld_q | do_resolve;

    if (do_write) begin
      valid_d[w_set][victim] = bus.accesstag_w[PTE_V];
      if (&valid_q[w_set]) begin
        rr_d[w_set] = (rr_q[w_set] == HWW'(WAYS - 1)) ? '0 : rr_q[w_set] + 1'b1;
      end
    end

    if (do_flush) begin
      state_d = ST_SWEEP;
      cnt_d   = '0;
    end

    // One set per cycle; the last set drops straight back to IDLE.
    if (state_q == ST_SWEEP) begin
      valid_d[cnt_q] = '0;
      rr_d[cnt_q]    = '0;
      cnt_d          = cnt_q + 1'b1;
      if (&cnt_q) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rr_q      <= rr_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      res_vld_q <= res_vld_d;
    end
  end

  always_comb begin
    sel_way   = '0;
    sel_ppn   = '0;
    sel_flags = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_way   = HWW'(i);
        sel_ppn   = way_ppn[i];
        sel_flags = way_flags[i];
      end
    end
  end

  // Way-side compare state is not reset; res_vld_q keeps it off the outputs
  // until the first lookup after reset has completed.
  assign bus.resolve_done = done_q;
  assign bus.hit          = res_vld_q & (|match);
  assign bus.multi_hit    = res_vld_q & ($countones(match) > 1);
  assign bus.hit_way      = res_vld_q ? sel_way   : '0;
  assign bus.phys_r       = res_vld_q ? sel_ppn   : '0;
  assign bus.accesstag_r  = res_vld_q ? sel_flags : '0;
  assign bus.busy         = (state_q == ST_SWEEP);
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_corevx_tlb_assoc.sv
// Bench for corevx_tlb_assoc: directed scenarios plus random traffic against
// an entry-level model of the TLB contents.
module tb_corevx_tlb_assoc;
  import corevx_tlb_pkg::*;

  localparam int EW = 4, WW = 2, VW = 20, PW = 22, AW = 9;
  localparam int SETS = 16, WAYS = 4, TW = VW - EW;
  localparam int RW = 1 + 1 + 2 + 8 + PW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  corevx_tlb_assoc_if #(.WAYS_W(WW), .VPN_W(VW), .PPN_W(PW), .ASID_W(AW)) bus ();

  corevx_tlb_assoc #(
    .ENTRIES_W (EW),
    .WAYS_W    (WW),
    .VPN_W     (VW),
    .PPN_W     (PW),
    .ASID_W    (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // model of TLB contents
  logic          m_vld  [SETS][WAYS];
  logic [TW-1:0] m_vtag [SETS][WAYS];
  logic [AW-1:0] m_asid [SETS][WAYS];
  logic [PW-1:0] m_ppn  [SETS][WAYS];
  logic [7:0]    m_tag  [SETS][WAYS];
  int            m_rr   [SETS];
  int            busy_left = 0;
  logic          exp_done  = 1'b0;

  // scoreboard: {hit, multi_hit, hit_way, accesstag, ppn}
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] held = '0;
  bit            chk_en = 1'b0;
  int            total = 0;
  int            bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
    end
  endtask

  // Applies one clock edge worth of TLB behaviour to the model.
  task automatic model_edge(input logic [1:0] c, input logic [VW-1:0] v, input logic [AW-1:0] a,
                            input logic [7:0] t, input logic [PW-1:0] p);
    int s;
    int n;
    int first;
    int vic;
    logic [TW-1:0] vt;
    s = int'(v[EW-1:0]);
    vt = v[VW-1:EW];
    exp_done = 1'b0;
    if (!rst_n) begin
      model_clear();
      busy_left = 0;
      held = '0;
      exp_q.delete();
      return;
    end
    if (busy_left > 0) begin
      busy_left--;
      return;
    end
    case (c)
      TLB_CMD_RESOLVE: begin
        n = 0;
        first = -1;
        for (int w = 0; w < WAYS; w++) begin
          if (m_vld[s][w] && m_vtag[s][w] == vt && (m_tag[s][w][PTE_G] || m_asid[s][w] == a)) begin
            n++;
            if (first < 0) first = w;
          end
        end
        if (first < 0) exp_q.push_back('0);
        else exp_q.push_back({1'b1, n > 1, 2'(first), m_tag[s][first], m_ppn[s][first]});
        exp_done = 1'b1;
      end
      TLB_CMD_WRITE: begin
        vic = -1;
        for (int w = 0; w < WAYS; w++) if (!m_vld[s][w] && vic < 0) vic = w;
        if (vic < 0) begin
          vic = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_vld[s][vic]  = t[PTE_V];
        m_vtag[s][vic] = vt;
        m_asid[s][vic] = a;
        m_ppn[s][vic]  = p;
        m_tag[s][vic]  = t;
      end
      TLB_CMD_FLUSH: begin
        model_clear();
        busy_left = SETS;
      end
      default: ;
    endcase
  endtask

  // driver
  task automatic drive(input logic [1:0] c, input logic [VW-1:0] v, input logic [AW-1:0] a,
                       input logic [7:0] t, input logic [PW-1:0] p);
    bus.command     = c;
    bus.vpn         = v;
    bus.asid        = a;
    bus.vpn_w       = v;
    bus.asid_w      = a;
    bus.accesstag_w = t;
    bus.phys_w      = p;
    @(posedge clk);
    model_edge(c, v, a, t, p);
    #1;
    bus.command = TLB_CMD_NONE;
  endtask

  task automatic idle_cycle();
    drive(TLB_CMD_NONE, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_cycle();
    rst_n = 1'b1;
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("resolve_done", bus.resolve_done, exp_done);
      check("busy", bus.busy, busy_left > 0);
      check("dbg_state", bus.dbg_state, busy_left > 0);
      if (bus.resolve_done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resolve: got resolve_done=1 expected no pending lookup at %0t", $time);
        end else begin
          held = exp_q.pop_front();
        end
      end
      check("hit", bus.hit, held[RW-1]);
      check("multi_hit", bus.multi_hit, held[RW-2]);
      check("hit_way", bus.hit_way, held[RW-3:RW-4]);
      check("accesstag_r", bus.accesstag_r, held[PW+7:PW]);
      check("phys_r", bus.phys_r, held[PW-1:0]);
    end
  end

  initial begin
    int nb;
    int r;
    logic [1:0] c;
    logic [7:0] t;
    bus.command = TLB_CMD_NONE;
    bus.vpn = '0; bus.asid = '0; bus.vpn_w = '0; bus.asid_w = '0;
    bus.accesstag_w = '0; bus.phys_w = '0;
    model_clear();

    rst_n = 1'b0;
    idle_cycle();
    do_reset();
    chk_en = 1'b1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.resolve_done, 0);
    check("rst_phys", bus.phys_r, 0);

    // miss on empty TLB
    drive(TLB_CMD_RESOLVE, 20'h12345, 9'd1, 8'h00, 22'h0);
    check("empty_done", bus.resolve_done, 1);
    check("empty_hit", bus.hit, 0);
    check("empty_phys", bus.phys_r, 0);

    // ASID match and global bypass
    drive(TLB_CMD_WRITE, 20'h12345, 9'd1, 8'h0F, 22'h2AAAA);
    drive(TLB_CMD_RESOLVE, 20'h12345, 9'd1, 8'h00, 22'h0);
    check("asid_hit", bus.hit, 1);
    check("asid_way", bus.hit_way, 0);
    check("asid_phys", bus.phys_r, 22'h2AAAA);
    check("asid_tag", bus.accesstag_r, 8'h0F);
    drive(TLB_CMD_RESOLVE, 20'h12345, 9'd2, 8'h00, 22'h0);
    check("asid_miss", bus.hit, 0);
    drive(TLB_CMD_WRITE, 20'h12345, 9'd2, 8'h2F, 22'h15555);
    drive(TLB_CMD_RESOLVE, 20'h12345, 9'd2, 8'h00, 22'h0);
    check("global_hit", bus.hit, 1);
    check("global_way", bus.hit_way, 1);
    check("global_phys", bus.phys_r, 22'h15555);
    drive(TLB_CMD_WRITE, 20'h00001, 9'd7, 8'h0F, 22'h3FFFF);
    check("hold_phys", bus.phys_r, 22'h15555);
    check("hold_done", bus.resolve_done, 0);

    // round-robin eviction in set 5
    do_reset();
    for (int vt = 1; vt <= 5; vt++)
      drive(TLB_CMD_WRITE, 20'((vt << 4) | 5), 9'd3, 8'h0F, 22'(32'h100 + vt));
    drive(TLB_CMD_RESOLVE, 20'h00015, 9'd3, 8'h00, 22'h0);
    check("evict_miss", bus.hit, 0);
    drive(TLB_CMD_RESOLVE, 20'h00055, 9'd3, 8'h00, 22'h0);
    check("evict_way", bus.hit_way, 0);
    check("evict_phys", bus.phys_r, 22'h105);
    drive(TLB_CMD_RESOLVE, 20'h00025, 9'd3, 8'h00, 22'h0);
    check("keep_way", bus.hit_way, 1);

    // duplicate entries
    drive(TLB_CMD_WRITE, 20'h00777, 9'd3, 8'h0F, 22'h11);
    drive(TLB_CMD_WRITE, 20'h00777, 9'd3, 8'h0F, 22'h22);
    drive(TLB_CMD_RESOLVE, 20'h00777, 9'd3, 8'h00, 22'h0);
    check("dup_hit", bus.hit, 1);
    check("dup_multi", bus.multi_hit, 1);
    check("dup_way", bus.hit_way, 0);
    check("dup_phys", bus.phys_r, 22'h11);

    // flush sweep
    drive(TLB_CMD_WRITE, 20'h0ABC0, 9'd3, 8'h0F, 22'h33);
    drive(TLB_CMD_FLUSH, '0, '0, '0, '0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) nb++;
      if (i == 5) begin
        drive(TLB_CMD_RESOLVE, 20'h00055, 9'd3, 8'h00, 22'h0);
        check("sweep_ignore", bus.resolve_done, 0);
      end else begin
        idle_cycle();
      end
    end
    check("busy_cycles", nb, 16);
    drive(TLB_CMD_RESOLVE, 20'h00777, 9'd3, 8'h00, 22'h0);
    check("flushed_miss", bus.hit, 0);
    check("flushed_done", bus.resolve_done, 1);

    // reset in the middle of a sweep
    drive(TLB_CMD_WRITE, 20'hABCDE, 9'd4, 8'h0F, 22'h3C3C3);
    drive(TLB_CMD_RESOLVE, 20'hABCDE, 9'd4, 8'h00, 22'h0);
    check("pre_rst_hit", bus.hit, 1);
    drive(TLB_CMD_FLUSH, '0, '0, '0, '0);
    repeat (5) idle_cycle();
    do_reset();
    check("abort_busy", bus.busy, 0);
    drive(TLB_CMD_RESOLVE, 20'hABCDE, 9'd4, 8'h00, 22'h0);
    check("abort_miss", bus.hit, 0);
    check("abort_done", bus.resolve_done, 1);

    // random traffic on a small key space so hits and evictions are common
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      c = (r < 45) ? TLB_CMD_RESOLVE : (r < 90) ? TLB_CMD_WRITE :
          (r < 92) ? TLB_CMD_FLUSH : TLB_CMD_NONE;
      t = 8'($urandom_range(0, 255));
      t[PTE_V] = ($urandom_range(0, 9) != 0);
      t[PTE_G] = ($urandom_range(0, 4) == 0);
      drive(c, {16'($urandom_range(0, 5)), 4'($urandom_range(0, 3))},
            9'($urandom_range(0, 2)), t, 22'($urandom));
    end
    repeat (3) idle_cycle();
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corevx_tlb_assoc.md
Name: corevx_tlb_assoc

Overview:
Parametrised set-associative TLB for the Sv32 MMU path. It is the next generation of the existing fixed 4-way TLB, and adds:
- ASID tagging with a global-page bypass
- victim selection that prefers invalid ways, with per-set round-robin otherwise
- a multi-cycle invalidate-all sweep with a busy indication

It sits between the load/store unit and the page-table walker. The LSU issues RESOLVE; the walker issues WRITE; SFENCE.VMA issues FLUSH.

Parameters:
ENTRIES_W, 4, log2 sets per way (sets = 2**ENTRIES_W)
WAYS_W, 2, log2 ways (WAYS = 2**WAYS_W; 0 allowed -> direct mapped)
VPN_W, 20, virtual page number width
PPN_W, 22, physical page number width
ASID_W, 9, address-space id width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
command  in  2  0=NONE, 1=RESOLVE, 2=WRITE, 3=FLUSH
vpn  in  VPN_W  resolve virtual page number
asid  in  ASID_W  resolve ASID
resolve_done  out  1  one-cycle pulse: result outputs valid
hit  out  1  resolve hit
multi_hit  out  1  more than one way matched (error indicator)
hit_way  out  WAYS_W (min 1)  matching way index
accesstag_r  out  8  PTE flags of hit entry (V,R,W,X,U,G,A,D at bits 0..7)
phys_r  out  PPN_W  physical page number of hit entry
vpn_w  in  VPN_W  write virtual page number
asid_w  in  ASID_W  write ASID
accesstag_w  in  8  write PTE flags
phys_w  in  PPN_W  write PPN
busy  out  1  flush sweep in progress; commands ignored

Behaviour:
- Address split: set = vpn[ENTRIES_W-1:0]; vtag = vpn[VPN_W-1:ENTRIES_W].
- Per-entry storage:
  - vtag, asid, ppn, accesstag in synchronous-read RAMs.
  - valid bit in flops (WAYS x sets), so victim selection is combinational.
- Reset (synchronous, rst_n low):
  - All valid bits cleared, all round-robin pointers = 0, FSM -> IDLE.
  - busy=0, resolve_done=0, hit=0, multi_hit=0, hit_way=0, accesstag_r=0, phys_r=0.
  - Reset asserted during a flush aborts the sweep; the reset itself already clears every valid bit.
- RESOLVE (accepted in IDLE):
  - Latency 1: resolve_done pulses in cycle N+1.
  - Way i matches when valid[set][i] && vtag_i==vtag && (accesstag_i[5] (G) || asid_i==asid).
  - hit = any match; hit_way = lowest matching index; accesstag_r/phys_r come from that way; multi_hit = popcount(matches) > 1.
  - On a miss, hit_way=0 and accesstag_r/phys_r=0.
  - The valid vector for the set is sampled at cycle N, so a WRITE/FLUSH issued in cycle N+1 does not corrupt the pending result.
  - All result outputs hold until the next RESOLVE completes. WRITE and FLUSH never modify them.
- WRITE (accepted in IDLE, single cycle):
  - Victim = lowest-index invalid way in the set, if any.
  - Otherwise victim = rr[set], and rr[set] increments modulo WAYS (wraps WAYS-1 -> 0). rr does not change when an invalid way is filled.
  - The write sets valid = accesstag_w[0], so a write with V=0 leaves the slot invalid.
  - Duplicate suppression is not performed; the walker writes only after a miss.
- FLUSH:
  - IDLE -> SWEEP with counter = 0; busy rises in the cycle after acceptance.
  - SWEEP: clears valid for all ways of set[counter] each cycle and increments counter. At counter == sets-1, clears that set and returns to IDLE.
  - busy is high for exactly 2**ENTRIES_W cycles.
  - rr pointers are also reset to 0 during the sweep.
  - Any command while busy=1 is ignored: no resolve_done, no write, no restart.
- NONE: no state change.

Decomposition:
- Shared package corevx_tlb_pkg:
  - command encodings TLB_CMD_NONE/RESOLVE/WRITE/FLUSH
  - PTE flag bit indices (V=0 … D=7)
  - FSM state enum {IDLE, SWEEP}
- One natural sub-module: corevx_tlb_assoc_way. It holds per-way RAMs built on mem_1w1r and produces a registered match and data.
- Top level contains the valid flops, rr pointers, victim select, priority/multi-hit mux and flush FSM.

Test Plan:
- Reset, then RESOLVE vpn=0x12345 asid=1 -> resolve_done next cycle, hit=0, phys_r=0, busy=0.
- WRITE vpn=0x12345 asid=1 accesstag=0x0F phys=0x2AAAA, then RESOLVE same vpn with asid=1 -> hit=1, hit_way=0, phys_r=0x2AAAA, accesstag_r=0x0F; with asid=2 -> hit=0; rewrite with accesstag=0x2F (G set) and asid=2 -> hit=1.
- Five WRITEs to set 5 (vtags 1..5, WAYS=4) -> ways 0..3 filled, 5th evicts way 0 (rr 0->1); RESOLVE vtag 1 -> miss, vtag 5 -> hit_way=0.
- Fill several sets, FLUSH -> busy high for exactly 16 cycles; a RESOLVE issued mid-sweep produces no resolve_done; all later resolves miss.
- Same vpn/asid written into two ways (via invalidate-free duplicate writes) -> hit=1, multi_hit=1, hit_way=0.
- Assert rst_n low at cycle 5 of a sweep -> busy=0 next cycle; a RESOLVE of a previously written entry misses.
